uart_tx: RTL and testbench

UART transmitter that pairs with the existing uart_rx receiver: 8N1-style framing, LSB first, line idles high. Accepts parallel words over a valid/ready handshake into a one-entry holding register, then serialises them with a programmable bit period. This allows back-to-back frames with a fixed one-cycle inter-frame gap. Sits between the host/control logic and the serial line pin; its output drives uart_rx's data_bit in loopback.

---
 rtl/uart_tx.sv | 143 ++++++++++++++
 tb/tb_uart_tx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: 8N1-style framing, LSB first, idle-high line, one-entry holding register.
// Bit period is latched per frame as max(CLKS_PER_BIT, 2); frames chain with a one-cycle DONE gap.
module uart_tx #(
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [12:0]           CLKS_PER_BIT,
  input  logic                  data_valid,
  input  logic [data_width-1:0] data_in,
  output logic                  data_ready,
  output logic                  tx_bit,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT,
    DONE
  } state_t;

  localparam logic [2:0] LAST_BIT = 3'(data_width - 1);

  state_t                state_q, state_d;
  logic [data_width-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [data_width-1:0] shift_q, shift_d;
  logic [12:0]           period_q, period_d;
  logic [12:0]           clk_cnt_q, clk_cnt_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic                  tx_bit_q, tx_bit_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  last_tick;
  logic                  load;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    period_d    = period_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    load        = 1'b0;
    last_tick   = (clk_cnt_q == period_q - 13'd1);

    case (state_q)
      IDLE, DONE: begin
        if (hold_full_q) load = 1'b1;
        else             state_d = IDLE;
      end
      START_BIT: begin
        if (last_tick) begin
          state_d   = DATA_BITS;
          clk_cnt_d = 13'd0;
          bit_cnt_d = 3'd0;
        end else begin
          clk_cnt_d = clk_cnt_q + 13'd1;
        end
      end
      DATA_BITS: begin
        if (last_tick) begin
          clk_cnt_d = 13'd0;
          shift_d   = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) state_d = STOP_BIT;
          else                       bit_cnt_d = bit_cnt_q + 3'd1;
        end else begin
          clk_cnt_d = clk_cnt_q + 13'd1;
        end
      end
      STOP_BIT: begin
        if (last_tick) begin
          state_d   = DONE;
          clk_cnt_d = 13'd0;
        end else begin
          clk_cnt_d = clk_cnt_q + 13'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Period is frozen here so mid-frame CLKS_PER_BIT changes cannot stretch a bit.
    if (load) begin
      state_d     = START_BIT;
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      period_d    = (CLKS_PER_BIT < 13'd2) ? 13'd2 : CLKS_PER_BIT;
      clk_cnt_d   = 13'd0;
      bit_cnt_d   = 3'd0;
    end

    // Accept and load are mutually exclusive: accept needs the register empty.
    if (data_valid && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_d      = data_in;
    end

    case (state_d)
      START_BIT: tx_bit_d = 1'b0;
      DATA_BITS: tx_bit_d = shift_d[0];
      default:   tx_bit_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      period_q    <= 13'd2;
      clk_cnt_q   <= 13'd0;
      bit_cnt_q   <= 3'd0;
      tx_bit_q    <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      period_q    <= period_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_bit_q    <= tx_bit_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign data_ready = !hold_full_q;
  assign tx_bit     = tx_bit_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-level model predicts the line, busy, done and ready per cycle,
// and a mid-bit sampling receiver decodes each frame on the done pulse.
module tb_uart_tx;
  localparam int DW = 8;
  localparam int N  = 40000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [12:0]   cpb;
  logic          data_valid;
  logic [DW-1:0] data_in;
  logic          data_ready, tx_bit, busy, done;

  uart_tx #(.data_width(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .CLKS_PER_BIT (cpb),
    .data_valid   (data_valid),
    .data_in      (data_in),
    .data_ready   (data_ready),
    .tx_bit       (tx_bit),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int ecnt   = 0;

  typedef struct {
    int            s;
    int            p;
    logic [DW-1:0] w;
  } frame_t;

  bit            exp_tx [N];
  bit            exp_busy [N];
  bit            exp_done [N];
  bit            act_tx [N];
  bit            m_hold_full = 1'b0;
  logic [DW-1:0] m_hold;
  int            m_free_edge = 0;
  bit            m_pend_acc = 1'b0;
  frame_t        fq [$];
  frame_t        fr;
  logic [DW-1:0] rx_w;
  int            nxt, per;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at edge %0d: got %0h expected %0h", tag, ecnt, act, expv);
    end
  endtask

  // Lay out one whole frame from its start edge: start, data LSB first, stop, DONE.
  task automatic schedule(input int s, input int p, input logic [DW-1:0] w);
    int len;
    len = (DW + 2) * p;
    if (s + len + 2 >= N) begin
      $display("FAIL sim_budget: edge %0d exceeds %0d", s + len, N);
      $fatal(1);
    end
    for (int i = 0; i < len; i++) begin
      int k;
      k = i / p;
      exp_tx[s+i]   = (k == 0) ? 1'b0 : (k <= DW) ? w[k-1] : 1'b1;
      exp_busy[s+i] = 1'b1;
    end
    exp_busy[s+len] = 1'b1;
    exp_done[s+len] = 1'b1;
    m_free_edge = s + len + 1;
    fq.push_back('{s: s, p: p, w: w});
  endtask

  task automatic model_reset();
    for (int i = ecnt; i < N && i <= m_free_edge; i++) begin
      exp_tx[i]   = 1'b1;
      exp_busy[i] = 1'b0;
      exp_done[i] = 1'b0;
    end
    m_free_edge = 0;
    m_hold_full = 1'b0;
    m_pend_acc  = 1'b0;
    fq.delete();
  endtask

  always @(posedge clk) ecnt <= ecnt + 1;

  // Checks the state after edge ecnt, then predicts what edge ecnt+1 does.
  always @(negedge clk) begin
    if (ecnt < N) act_tx[ecnt] = tx_bit;
    if (rst) begin
      chk("rst_tx",   32'(tx_bit), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rdy",  32'(data_ready), 32'd1);
      model_reset();
    end else begin
      chk("tx",   32'(tx_bit), 32'(exp_tx[ecnt]));
      chk("busy", 32'(busy), 32'(exp_busy[ecnt]));
      chk("done", 32'(done), 32'(exp_done[ecnt]));
      chk("rdy",  32'(data_ready), 32'(!m_hold_full));
      if (done) begin
        if (fq.size() == 0) begin
          chk("done_unexpected", 32'd1, 32'd0);
        end else begin
          fr = fq.pop_front();
          for (int j = 0; j < DW; j++) rx_w[j] = act_tx[fr.s + (1 + j) * fr.p + fr.p / 2];
          chk("rx_word", 32'(rx_w), 32'(fr.w));
          chk("done_edge", 32'(ecnt), 32'(fr.s + (DW + 2) * fr.p));
        end
      end
      nxt = ecnt + 1;
      m_pend_acc = 1'b0;
      if (m_hold_full) begin
        if (nxt >= m_free_edge) begin
          per = (cpb < 13'd2) ? 2 : int'(cpb);
          schedule(nxt, per, m_hold);
          m_hold_full = 1'b0;
        end
      end else if (data_valid) begin
        m_hold_full = 1'b1;
        m_hold      = data_in;
        m_pend_acc  = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [DW-1:0] w);
    bit ok;
    ok = 1'b0;
    data_valid = 1'b1;
    data_in    = w;
    for (int k = 0; k < 5000 && !ok; k++) begin
      tick(1);
      if (m_pend_acc) ok = 1'b1;
    end
    data_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 8000 && !ok; k++) begin
      if (!m_hold_full && ecnt > m_free_edge) ok = 1'b1;
      else tick(1);
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_edge_in_frame(input int offs);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 5000 && !ok; k++) begin
      if (fq.size() > 0 && ecnt >= fq[0].s + offs) ok = 1'b1;
      else tick(1);
    end
    if (!ok) chk("frame_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < N; i++) exp_tx[i] = 1'b1;
    cpb        = 13'd4;
    data_valid = 1'b0;
    data_in    = '0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    tick(2);

    // Single frame and back-to-back pair at 4 clocks per bit.
    send(8'hA5);
    wait_idle();
    send(8'h3C);
    send(8'hC3);
    wait_idle();

    // Loopback word set at 16 clocks per bit, chained.
    cpb = 13'd16;
    send(8'h00); send(8'hFF); send(8'h55); send(8'h81);
    wait_idle();

    // Asynchronous reset while data bit 3 of 0xF0 is on the line.
    cpb = 13'd4;
    send(8'hF0);
    wait_edge_in_frame(4 * 4 + 1);
    #1 rst = 1'b1;
    #1;
    chk("async_tx",   32'(tx_bit), 32'd1);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_rdy",  32'(data_ready), 32'd1);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    tick(60);
    chk("no_residual", 32'(fq.size()), 32'd0);

    // Period latched at frame start; the queued frame picks up the new value.
    cpb = 13'd8;
    send(8'h0F);
    wait_edge_in_frame(3 * 8 + 1);
    cpb = 13'd3;
    send(8'h96);
    wait_idle();

    // Periods below two clamp to two.
    cpb = 13'd1; send(8'h6B); wait_idle();
    cpb = 13'd0; send(8'h2D); wait_idle();

    // Valid held high with data changing every cycle.
    cpb = 13'd3;
    data_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      data_in = DW'($urandom);
      if (k % 97 == 0) cpb = 13'($urandom_range(2, 5));
      tick(1);
    end
    data_valid = 1'b0;
    wait_idle();
    chk("holdoff_drained", 32'(fq.size()), 32'd0);

    // Random words, gaps and periods, including mid-frame period changes.
    for (int k = 0; k < 30; k++) begin
      cpb = 13'($urandom_range(0, 12));
      send(DW'($urandom));
      if ($urandom_range(0, 2) == 0) cpb = 13'($urandom_range(1, 12));
      tick($urandom_range(0, 40));
    end
    wait_idle();
    tick(5);
    chk("final_drained", 32'(fq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
